// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage: MIPS MEM stage with data-memory handshake and MEM/WB register |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] o_in,
  input  logic [31:0] b_in,
  input  logic [31:0] insn_in,
  input  logic [5:0]  aluop_in,
  input  logic        dmwe_in,
  input  logic        rwe_in,
  input  logic        rwd_in,
  input  logic        rdst_in,
  input  logic        dm_byte_in,
  input  logic        dm_half_in,
  output logic        stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic [31:0] o,
  output logic [31:0] d,
  output logic [31:0] insn,
  output logic [5:0]  aluop,
  output logic        rwe,
  output logic        rwd,
  output logic        rdst,
  output logic        dm_byte,
  output logic        dm_half,
  output logic        dmwe,
  output logic        align_err,
  output logic        bus_err
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;

  logic        lat_we, lat_rwe, lat_rwd, lat_rdst, lat_byte, lat_half;
  logic [31:0] lat_o, lat_wdata, lat_insn;
  logic [5:0]  lat_aluop;
  logic [3:0]  lat_be;

  logic        is_mem, misaligned, accept_mem, finish;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, load_d;

  assign is_mem     = dmwe_in | rwd_in;
  assign misaligned = ~dm_byte_in & (dm_half_in ? o_in[0] : (o_in[1:0] != 2'b00));
  assign accept_mem = (state == S_IDLE) & in_valid & is_mem & ~misaligned;
  assign finish     = (state == S_WAIT) & (dm_ack | (cnt == LAST));

  // Big-endian lanes: be[3] is bits [31:24], i.e. byte offset 0.
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = b_in;
    if (dm_byte_in) begin
      be_in    = 4'b1000 >> o_in[1:0];
      wdata_in = {4{b_in[7:0]}};
    end else if (dm_half_in) begin
      be_in    = o_in[1] ? 4'b0011 : 4'b1100;
      wdata_in = {2{b_in[15:0]}};
    end
  end

  // Move the addressed byte/halfword to the top of the word for writeback.
  always_comb begin
    load_d = dm_rdata;
    if (lat_byte)
      load_d = dm_rdata << {lat_o[1:0], 3'b000};
    else if (lat_half)
      load_d = lat_o[1] ? {dm_rdata[15:0], 16'h0000} : dm_rdata;
  end

  assign dm_req   = (state == S_WAIT);
  assign stall    = dm_req;
  assign dm_we    = dm_req & lat_we;
  assign dm_addr  = dm_req ? {lat_o[31:2], 2'b00} : 32'h0;
  assign dm_be    = dm_req ? lat_be : 4'h0;
  assign dm_wdata = dm_req ? lat_wdata : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_mem) state_nxt = S_WAIT;
      S_WAIT:  if (finish)     state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_rwe   <= 1'b0;
      lat_rwd   <= 1'b0;
      lat_rdst  <= 1'b0;
      lat_byte  <= 1'b0;
      lat_half  <= 1'b0;
      lat_o     <= 32'h0;
      lat_wdata <= 32'h0;
      lat_insn  <= 32'h0;
      lat_aluop <= 6'h0;
      lat_be    <= 4'h0;
      wb_valid  <= 1'b0;
      o         <= 32'h0;
      d         <= 32'h0;
      insn      <= 32'h0;
      aluop     <= 6'h0;
      rwe       <= 1'b0;
      rwd       <= 1'b0;
      rdst      <= 1'b0;
      dm_byte   <= 1'b0;
      dm_half   <= 1'b0;
      dmwe      <= 1'b0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      wb_valid  <= 1'b0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      if (state == S_IDLE) begin
        cnt <= '0;
        if (accept_mem) begin
          lat_we    <= dmwe_in;
          lat_rwe   <= rwe_in & ~dmwe_in;
          lat_rwd   <= rwd_in;
          lat_rdst  <= rdst_in;
          lat_byte  <= dm_byte_in;
          lat_half  <= dm_half_in;
          lat_o     <= o_in;
          lat_wdata <= wdata_in;
          lat_insn  <= insn_in;
          lat_aluop <= aluop_in;
          lat_be    <= be_in;
        end else if (in_valid) begin
          // Non-memory ops and misaligned accesses retire in one cycle.
          wb_valid  <= 1'b1;
          o         <= o_in;
          d         <= 32'h0;
          insn      <= insn_in;
          aluop     <= aluop_in;
          rwd       <= rwd_in;
          rdst      <= rdst_in;
          dm_byte   <= dm_byte_in;
          dm_half   <= dm_half_in;
          rwe       <= is_mem ? 1'b0 : rwe_in;
          dmwe      <= 1'b0;
          align_err <= is_mem;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (finish) begin
          cnt      <= '0;
          wb_valid <= 1'b1;
          o        <= lat_o;
          insn     <= lat_insn;
          aluop    <= lat_aluop;
          rwd      <= lat_rwd;
          rdst     <= lat_rdst;
          dm_byte  <= lat_byte;
          dm_half  <= lat_half;
          rwe      <= dm_ack & lat_rwe;
          dmwe     <= dm_ack & lat_we;
          d        <= (dm_ack & ~lat_we) ? load_d : 32'h0;
          bus_err  <= ~dm_ack;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_stage: directed vector bench for mem_stage                        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] o_in = 32'h0, b_in = 32'h0, insn_in = 32'h0;
  logic [5:0]  aluop_in = 6'h0;
  logic        dmwe_in = 1'b0, rwe_in = 1'b0, rwd_in = 1'b0, rdst_in = 1'b0;
  logic        dm_byte_in = 1'b0, dm_half_in = 1'b0;
  logic        stall, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = 32'h0;
  logic        wb_valid;
  logic [31:0] o, d, insn;
  logic [5:0]  aluop;
  logic        rwe, rwd, rdst, dm_byte, dm_half, dmwe, align_err, bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .o_in(o_in), .b_in(b_in), .insn_in(insn_in), .aluop_in(aluop_in),
    .dmwe_in(dmwe_in), .rwe_in(rwe_in), .rwd_in(rwd_in), .rdst_in(rdst_in),
    .dm_byte_in(dm_byte_in), .dm_half_in(dm_half_in),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .o(o), .d(d), .insn(insn), .aluop(aluop),
    .rwe(rwe), .rwd(rwd), .rdst(rdst), .dm_byte(dm_byte), .dm_half(dm_half),
    .dmwe(dmwe), .align_err(align_err), .bus_err(bus_err)
  );

  // ctl = {dmwe, rwe, rwd, byte, half}; flags = {rwe, dmwe, align_err} expected.
  typedef struct {
    logic [31:0] o_in;
    logic [31:0] b_in;
    logic [31:0] insn;
    logic [5:0]  aluop;
    logic [4:0]  ctl;
    int          waitc;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] d;
    logic [2:0]  flags;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    o_in     = v.o_in;
    b_in     = v.b_in;
    insn_in  = v.insn;
    aluop_in = v.aluop;
    {dmwe_in, rwe_in, rwd_in, dm_byte_in, dm_half_in} = v.ctl;
    rdst_in  = v.insn[0];
    in_valid = 1'b1;
  endtask

  task automatic apply(input int idx);
    vec_t v;
    logic [31:0] mask;
    v = vecs[idx];
    @(negedge clk);
    drive(v);
    dm_ack = 1'b0;
    @(posedge clk); #1;
    if (v.waitc > 0) begin
      mask = {{8{v.be[3]}}, {8{v.be[2]}}, {8{v.be[1]}}, {8{v.be[0]}}};
      for (int w = 1; w <= v.waitc; w++) begin
        chk($sformatf("v%0d dm_req", idx), {31'b0, dm_req}, 32'h1);
        chk($sformatf("v%0d stall", idx), {31'b0, stall}, 32'h1);
        chk($sformatf("v%0d wb_valid_busy", idx), {31'b0, wb_valid}, 32'h0);
        chk($sformatf("v%0d dm_addr", idx), dm_addr, {v.o_in[31:2], 2'b00});
        chk($sformatf("v%0d dm_be", idx), {28'b0, dm_be}, {28'b0, v.be});
        chk($sformatf("v%0d dm_we", idx), {31'b0, dm_we}, {31'b0, v.ctl[4]});
        if (v.ctl[4])
          chk($sformatf("v%0d dm_wdata", idx), dm_wdata & mask, v.wdata & mask);
        if (w == v.waitc) begin
          dm_ack   = 1'b1;
          dm_rdata = v.rdata;
        end
        @(posedge clk); #1;
      end
      dm_ack = 1'b0;
    end
    in_valid = 1'b0;
    chk($sformatf("v%0d dm_req_after", idx), {31'b0, dm_req}, 32'h0);
    chk($sformatf("v%0d stall_after", idx), {31'b0, stall}, 32'h0);
    chk($sformatf("v%0d wb_valid", idx), {31'b0, wb_valid}, 32'h1);
    chk($sformatf("v%0d o", idx), o, v.o_in);
    chk($sformatf("v%0d insn", idx), insn, v.insn);
    chk($sformatf("v%0d aluop", idx), {26'b0, aluop}, {26'b0, v.aluop});
    chk($sformatf("v%0d d", idx), d, v.d);
    chk($sformatf("v%0d rwe", idx), {31'b0, rwe}, {31'b0, v.flags[2]});
    chk($sformatf("v%0d dmwe", idx), {31'b0, dmwe}, {31'b0, v.flags[1]});
    chk($sformatf("v%0d align_err", idx), {31'b0, align_err}, {31'b0, v.flags[0]});
    chk($sformatf("v%0d bus_err", idx), {31'b0, bus_err}, 32'h0);
    @(posedge clk); #1;
    chk($sformatf("v%0d wb_valid_pulse", idx), {31'b0, wb_valid}, 32'h0);
  endtask

  initial begin
    int reqs;
    vecs[0]  = '{32'h12345678, 32'h0,        32'h00851020, 6'd2, 5'b01000, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        3'b100};
    vecs[1]  = '{32'h00001002, 32'h000000AB, 32'hA0450002, 6'd2, 5'b10010, 1, 32'h0,        4'b0010, 32'hABABABAB, 32'h0,        3'b010};
    vecs[2]  = '{32'h00002003, 32'h0,        32'h80450003, 6'd2, 5'b01110, 3, 32'h112233F4, 4'b0001, 32'h0,        32'hF4000000, 3'b100};
    vecs[3]  = '{32'h00002002, 32'h0,        32'h84450002, 6'd2, 5'b01101, 2, 32'hAAAA8001, 4'b0011, 32'h0,        32'h80010000, 3'b100};
    vecs[4]  = '{32'h00003001, 32'h00000055, 32'hAC450001, 6'd2, 5'b10000, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        3'b001};
    vecs[5]  = '{32'h00001000, 32'h0000BEEF, 32'hA4450000, 6'd2, 5'b10001, 1, 32'h0,        4'b1100, 32'hBEEFBEEF, 32'h0,        3'b010};
    vecs[6]  = '{32'h00001004, 32'hDEADBEEF, 32'hAC450004, 6'd2, 5'b10000, 2, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0,        3'b010};
    vecs[7]  = '{32'h00001008, 32'h01020304, 32'hAC450008, 6'd2, 5'b11100, 1, 32'h0,        4'b1111, 32'h01020304, 32'h0,        3'b010};
    vecs[8]  = '{32'h0000200C, 32'h0,        32'h8C45000C, 6'd2, 5'b01100, 1, 32'hCAFEF00D, 4'b1111, 32'h0,        32'hCAFEF00D, 3'b100};
    vecs[9]  = '{32'h00002001, 32'h0,        32'h80450001, 6'd2, 5'b01110, 1, 32'h11223344, 4'b0100, 32'h0,        32'h22334400, 3'b100};
    vecs[10] = '{32'h00002001, 32'h0,        32'h84450001, 6'd2, 5'b01101, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        3'b001};
    vecs[11] = '{32'h00002000, 32'h0,        32'h84450000, 6'd2, 5'b01101, 1, 32'h12345678, 4'b1100, 32'h0,        32'h12345678, 3'b100};
    vecs[12] = '{32'h00002002, 32'h0,        32'h80450002, 6'd2, 5'b01110, 2, 32'h11223344, 4'b0010, 32'h0,        32'h33440000, 3'b100};
    vecs[13] = '{32'h0BADF00D, 32'h0,        32'h00851021, 6'd3, 5'b01000, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        3'b100};

    #12;
    chk("reset wb_valid", {31'b0, wb_valid}, 32'h0);
    chk("reset dm_req", {31'b0, dm_req}, 32'h0);
    chk("reset stall", {31'b0, stall}, 32'h0);
    chk("reset o", o, 32'h0);
    chk("reset d", d, 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    dm_ack = 1'b1;
    @(posedge clk); #1;
    chk("idle ack ignored wb_valid", {31'b0, wb_valid}, 32'h0);
    chk("idle ack ignored stall", {31'b0, stall}, 32'h0);
    dm_ack = 1'b0;

    for (int i = 0; i < 13; i++) apply(i);

    // Timeout: word load never acknowledged.
    @(negedge clk);
    drive('{32'h00004000, 32'h0, 32'h8C464000, 6'd2, 5'b01100, 0, 32'h0, 4'hF, 32'h0, 32'h0, 3'b000});
    @(posedge clk); #1;
    reqs = 0;
    for (int i = 0; i < 40 && !wb_valid; i++) begin
      if (dm_req) reqs++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("timeout req cycles", reqs, 32'd15);
    chk("timeout wb_valid", {31'b0, wb_valid}, 32'h1);
    chk("timeout bus_err", {31'b0, bus_err}, 32'h1);
    chk("timeout rwe", {31'b0, rwe}, 32'h0);
    chk("timeout d", d, 32'h0);
    chk("timeout dm_req", {31'b0, dm_req}, 32'h0);
    chk("timeout o", o, 32'h00004000);
    @(posedge clk); #1;
    chk("timeout bus_err pulse", {31'b0, bus_err}, 32'h0);
    apply(0);

    // Reset asserted mid-transaction.
    @(negedge clk);
    drive('{32'h00002004, 32'h0, 32'h8C452004, 6'd2, 5'b01100, 0, 32'h0, 4'hF, 32'h0, 32'h0, 3'b000});
    @(posedge clk); #1;
    chk("rstwait dm_req before", {31'b0, dm_req}, 32'h1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rstwait dm_req", {31'b0, dm_req}, 32'h0);
    chk("rstwait stall", {31'b0, stall}, 32'h0);
    chk("rstwait wb_valid", {31'b0, wb_valid}, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
